// File: rtl/qracc_pkg.sv
// ============================================================================
// Module      : qracc_pkg
// Description : Shared types and helpers for the MAC output drain path:
//               drain FSM state encoding and beat/index sizing functions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package qracc_pkg;

  // Drain FSM: IDLE presents nothing, SEND presents the head vector beat by beat
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } drain_state_t;

  // Number of bus beats needed to carry one packed result vector
  function automatic int unsigned beat_count(input int unsigned elems,
                                             input int unsigned bits,
                                             input int unsigned bus_w);
    return (elems * bits) / bus_w;
  endfunction

  // Index width for a counter over n positions, never narrower than one bit
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vec_fifo.sv
// ============================================================================
// Module      : vec_fifo
// Description : Whole-vector FIFO with wrap-around pointers and an occupancy
//               count. Storage is not reset; only pointers and count are.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vec_fifo
  import qracc_pkg::*;
#(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  localparam int unsigned    c_PW       = idx_width(DEPTH);
  localparam logic [c_PW-1:0] c_LAST_PTR = c_PW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_PW-1:0]  r_wr_ptr;
  logic [c_PW-1:0]  r_rd_ptr;
  logic [CW-1:0]    r_count;

  // Vector storage write; a push into a slot being popped this cycle is safe
  // because the head is read combinationally before the edge
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointers wrap modulo DEPTH; count tracks net occupancy
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));

endmodule

`default_nettype wire

// File: rtl/mac_out_drain.sv
// ============================================================================
// Module      : mac_out_drain
// Description : Buffers MAC result vectors and drains them as bus-width beats
//               over a valid/ready interface, with a sticky overflow flag for
//               vectors arriving while the buffer is full.
//               Optional build macro QRACC_OUT_RELU_EN: lanes with the sign
//               bit set are zeroed as they are written into the FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_out_drain
  import qracc_pkg::*;
#(
  parameter int unsigned outputElements = 32,
  parameter int unsigned outputBits     = 8,
  parameter int unsigned busWidth       = 32,
  parameter int unsigned fifoDepth      = 2
) (
  input  logic                                     clk,
  input  logic                                     nrst,
  input  logic                                     mac_valid_i,
  input  logic [outputElements-1:0][outputBits-1:0] mac_data_i,
  output logic                                     space_o,
  output logic                                     overflow_o,
  input  logic                                     clear_i,
  output logic [busWidth-1:0]                      data_o,
  output logic                                     valid_o,
  input  logic                                     ready_i,
  output logic                                     last_o
);

  localparam int unsigned     c_BEATS = beat_count(outputElements, outputBits, busWidth);
  localparam int unsigned     c_VEC_W = outputElements * outputBits;
  localparam int unsigned     c_BW    = idx_width(c_BEATS);
  localparam int unsigned     c_CW    = $clog2(fifoDepth + 1);
  localparam logic [c_BW-1:0] c_LAST  = c_BW'(c_BEATS - 1);

  drain_state_t r_state, w_state_next;
  logic [c_BW-1:0] r_beat;
  logic            r_ovf;

  logic [outputElements-1:0][outputBits-1:0] w_lanes_in;
  logic [c_VEC_W-1:0]                        w_head;
  logic [c_BEATS-1:0][busWidth-1:0]          w_beats;
  logic [c_CW-1:0]                           w_count;
  logic w_full, w_empty, w_push, w_pop, w_drop, w_hs, w_last, w_valid;

  // Per-lane write-side conditioning
  for (genvar gi = 0; gi < outputElements; gi++) begin : g_lane
`ifdef QRACC_OUT_RELU_EN
    assign w_lanes_in[gi] = mac_data_i[gi][outputBits-1] ? '0 : mac_data_i[gi];
`else
    assign w_lanes_in[gi] = mac_data_i[gi];
`endif
  end

  // A last-beat pop frees a slot in the same cycle, so a push into a full
  // FIFO is still accepted then
  assign w_hs   = w_valid && ready_i;
  assign w_last = (r_beat == c_LAST);
  assign w_pop  = w_hs && w_last;
  assign w_push = mac_valid_i && (!w_full || w_pop);
  assign w_drop = mac_valid_i && w_full && !w_pop;

  vec_fifo #(
    .WIDTH (c_VEC_W),
    .DEPTH (fifoDepth),
    .CW    (c_CW)
  ) u_fifo (
    .clk     (clk),
    .nrst    (nrst),
    .i_push  (w_push),
    .i_din   (w_lanes_in),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_beats = w_head;

  // Drain FSM state register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state and beat outputs; an arriving push starts SEND directly so the
  // first beat appears one cycle after mac_valid_i
  always_comb begin
    w_state_next = r_state;
    w_valid      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_push || !w_empty) w_state_next = ST_SEND;
      end
      ST_SEND: begin
        w_valid = 1'b1;
        if (w_pop && !w_push && (w_count == c_CW'(1))) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Beat counter advances only on handshake and wraps after the last beat
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)     r_beat <= '0;
    else if (w_hs) r_beat <= w_last ? '0 : r_beat + 1'b1;
  end

  // Sticky overflow; a drop in the same cycle as clear wins
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)        r_ovf <= 1'b0;
    else if (w_drop)  r_ovf <= 1'b1;
    else if (clear_i) r_ovf <= 1'b0;
  end

  assign valid_o    = w_valid;
  assign last_o     = w_valid && w_last;
  assign data_o     = w_valid ? w_beats[r_beat] : '0;
  assign overflow_o = r_ovf;
  assign space_o    = (w_count < c_CW'(fifoDepth));

endmodule

`default_nettype wire

// File: doc/mac_out_drain.md
MAC_OUT_DRAIN -- requirements
Module: mac_out_drain

Interface
REQ-001 SHALL have parameter outputElements, default 32, the number of MAC result lanes per vector.
REQ-002 SHALL have parameter outputBits, default 8, the width of each signed result lane.
REQ-003 SHALL have parameter busWidth, default 32, the output beat width; outputElements*outputBits SHALL be an integer multiple of busWidth.
REQ-004 SHALL have parameter fifoDepth, default 2, the number of whole result vectors buffered.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port nrst, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port mac_valid_i, input, 1, one-cycle pulse marking a result vector from the accumulator.
REQ-008 SHALL have port mac_data_i, input, [outputElements-1:0][outputBits-1:0], the result vector; lane i is two's complement.
REQ-009 SHALL have port space_o, output, 1, high when at least one FIFO entry is free.
REQ-010 SHALL have port overflow_o, output, 1, sticky flag for a dropped vector.
REQ-011 SHALL have port clear_i, input, 1, synchronous clear of overflow_o.
REQ-012 SHALL have port data_o, output, busWidth, the current output beat.
REQ-013 SHALL have port valid_o, output, 1, the output beat is valid.
REQ-014 SHALL have port ready_i, input, 1, downstream accepts the beat.
REQ-015 SHALL have port last_o, output, 1, marks the final beat of a vector.

Function
REQ-016 SHALL capture mac_data_i into the FIFO tail on every cycle with mac_valid_i high and the FIFO not full; no ready exists toward the accumulator.
REQ-017 SHALL, on mac_valid_i with the FIFO full, drop the vector, leave FIFO contents unchanged, and set overflow_o on the next edge.
REQ-018 SHALL hold overflow_o until clear_i is sampled high; if clear_i and a drop occur in the same cycle, overflow_o SHALL end high.
REQ-019 SHALL split each vector into BEATS = outputElements*outputBits/busWidth beats; beat k carries bits [k*busWidth +: busWidth] of the packed vector, so lane 0 is in the LSBs of beat 0.
REQ-020 SHALL use a two-state FSM: IDLE (valid_o low) goes to SEND when the FIFO is non-empty; SEND goes to IDLE after the last beat handshake when the FIFO is empty after that pop.
REQ-021 SHALL have a minimum latency of one cycle from mac_valid_i to valid_o.
REQ-022 SHALL advance the beat counter only on valid_o && ready_i; data_o, last_o and valid_o SHALL stay stable while valid_o && !ready_i.
REQ-023 SHALL drive last_o high only when the beat counter equals BEATS-1.
REQ-024 SHALL pop the FIFO head and wrap the counter to 0 on the last-beat handshake; if the FIFO is non-empty after that pop, beat 0 of the next vector SHALL be presented on the following cycle with no idle gap.
REQ-025 SHALL, on push and last-beat pop in the same cycle with the FIFO full, accept the push, since the freed slot counts and the vector is not dropped.
REQ-026 SHALL compute space_o combinationally as FIFO count < fifoDepth.
REQ-027 SHALL wrap the FIFO read and write pointers modulo fifoDepth.

Reset
REQ-028 SHALL, on nrst low at any time, including mid-vector, asynchronously clear the FIFO pointers and count, the beat counter, and the FSM (to IDLE), and drive valid_o=0, last_o=0, overflow_o=0, space_o=1 and data_o=0.
REQ-029 SHALL discard any partially sent vector on reset; no resume occurs.

Configuration
REQ-030 SHALL support macro QRACC_OUT_RELU_EN; when defined, each lane with its MSB set SHALL be replaced by 0 at FIFO write; when undefined, lanes SHALL pass unmodified.

Structure
REQ-031 SHALL define a shared package qracc_pkg with the FSM state enum (drain_state_t) and a beat-count constant function.
REQ-032 SHALL place the FIFO storage in one sub-module, vec_fifo, with push/pop/full/empty/count; packing, FSM and the flag logic SHALL remain in mac_out_drain.

Verification
REQ-033 SHALL cover: one vector with lanes 0..31 = 0x00..0x1F and ready_i=1 -> 8 beats, beat0=0x03020100, last_o on beat 7, valid_o first high 1 cycle after mac_valid_i.
REQ-034 SHALL cover: ready_i toggling 1010... during a vector -> data_o stable during stalls and all 8 beats delivered in order.
REQ-035 SHALL cover: 3 pulses with ready_i=0 and fifoDepth=2 -> third vector dropped, overflow_o=1, space_o=0; clear_i -> overflow_o=0.
REQ-036 SHALL cover: push coinciding with the last-beat handshake while full -> no overflow, and the next vector starts the following cycle.
REQ-037 SHALL cover: nrst low at beat 3 -> valid_o=0 immediately, FIFO empty, space_o=1.
REQ-038 SHALL cover: with QRACC_OUT_RELU_EN defined, lane value 0x80 -> 0x00 and 0x7F -> 0x7F; without the macro, both pass unchanged.
